sar_track_timer: RTL and testbench

SAR_TRACK_TIMER -- requirements
Module: sar_track_timer

---
 rtl/sar_track_timer.sv | 119 +++++++++++
 tb/tb_sar_track_timer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_track_timer.sv
// SAR conversion interval timer with a one-deep tagged result buffer and inverted code taps.
// Optional min/max interval history is built when SAR_TRACK_TIMER_HIST_EN is defined.
module sar_track_timer #(
   parameter int DATA     = 8,
   parameter int TIMER    = 8,
   parameter int CHANNELS = 4,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             ClockT,
   input  logic             Reset,
   input  logic [1:0]       StateP,
   input  logic [DATA-1:0]  SAROut,
   input  logic             Inc,
   input  logic             Dcr,
   input  logic             Ack,
   output logic             Ready,
   output logic [DATA-1:0]  DataOut,
   output logic [TIMER-1:0] TimerOut,
   output logic [CW-1:0]    ChanOut,
   output logic [DATA-1:0]  SAROutI,
   output logic [DATA-1:0]  SAROutD,
   output logic [DATA-1:0]  SAROutC,
   output logic             Overflow,
   output logic             Timeout
`ifdef SAR_TRACK_TIMER_HIST_EN
   ,
   output logic [TIMER-1:0] TimerMin,
   output logic [TIMER-1:0] TimerMax
`endif
);

   logic             flagConv;
   logic             flagConvQ;
   logic [TIMER-1:0] cnt;
   logic [CW-1:0]    chan;
   logic             cntMax;
   logic             evt;
   logic             accept;
   logic             drop;
   logic             tracking;

   always_comb begin
      flagConv = 1'b0;
      case (StateP)
         2'b00:   flagConv = Inc | Dcr;
         2'b11:   flagConv = 1'b0;
         default: flagConv = 1'b1;
      endcase
   end

   assign tracking = (StateP == 2'b00) || (StateP == 2'b11);
   assign cntMax   = &cnt;
   assign evt      = (flagConv & ~flagConvQ) | cntMax;

   // Result handshake: Ready=1 holds a valid result until Ack is seen at a
   // rising edge. An event while Ready=1 and Ack=0 is dropped (Overflow sticks);
   // an event coinciding with Ack replaces the result and Ready stays high.
   assign accept = evt & (~Ready | Ack);
   assign drop   = evt & Ready & ~Ack;

   always_ff @(posedge ClockT or posedge Reset) begin
      if (Reset) begin
         flagConvQ <= 1'b0;
         cnt       <= '0;
         chan      <= '0;
         Ready     <= 1'b0;
         DataOut   <= DATA'(1);
         TimerOut  <= '0;
         ChanOut   <= '0;
         Timeout   <= 1'b0;
         Overflow  <= 1'b0;
      end else begin
         flagConvQ <= flagConv;
         cnt       <= evt ? TIMER'(1) : cnt + TIMER'(1);
         if (accept) begin
            Ready    <= 1'b1;
            DataOut  <= SAROut;
            TimerOut <= cnt;
            ChanOut  <= chan;
            Timeout  <= cntMax;
            chan     <= (chan == CW'(CHANNELS - 1)) ? '0 : chan + CW'(1);
         end else if (Ack && Ready) begin
            Ready <= 1'b0;
         end
         if (drop) begin
            Overflow <= 1'b1;
         end
      end
   end

   // Increment/decrement taps only follow the code while tracking or sampling;
   // during conversion they keep the last tracked values.
   always_ff @(posedge ClockT or posedge Reset) begin
      if (Reset) begin
         SAROutI <= '1;
         SAROutD <= '1;
         SAROutC <= '1;
      end else begin
         SAROutC <= ~SAROut;
         if (tracking) begin
            SAROutI <= (&SAROut) ? ~(SAROut - DATA'(1)) : ~SAROut;
            SAROutD <= (SAROut == '0) ? '1 : ~(SAROut - DATA'(1));
         end
      end
   end

`ifdef SAR_TRACK_TIMER_HIST_EN
   always_ff @(posedge ClockT or posedge Reset) begin
      if (Reset) begin
         TimerMin <= '1;
         TimerMax <= '0;
      end else if (accept && !cntMax) begin
         if (cnt < TimerMin) TimerMin <= cnt;
         if (cnt > TimerMax) TimerMax <= cnt;
      end
   end
`endif

endmodule

// File: tb/tb_sar_track_timer.sv
// Self-checking bench for sar_track_timer: a cycle model predicts each accepted result into a queue.
// Define SAR_TRACK_TIMER_HIST_EN to also check the min/max history outputs.
module tb_sar_track_timer;
  localparam int DATA = 8;
  localparam int TIMER = 8;
  localparam int CHANNELS = 4;
  localparam int CW = 2;
  localparam int RW = 1 + CW + TIMER + DATA;

  logic ClockT = 1'b0;
  logic Reset = 1'b1;
  logic [1:0] StateP = 2'b00;
  logic [DATA-1:0] SAROut = '0;
  logic Inc = 1'b0;
  logic Dcr = 1'b0;
  logic Ack = 1'b0;
  logic Ready;
  logic [DATA-1:0] DataOut;
  logic [TIMER-1:0] TimerOut;
  logic [CW-1:0] ChanOut;
  logic [DATA-1:0] SAROutI;
  logic [DATA-1:0] SAROutD;
  logic [DATA-1:0] SAROutC;
  logic Overflow;
  logic Timeout;
`ifdef SAR_TRACK_TIMER_HIST_EN
  logic [TIMER-1:0] TimerMin;
  logic [TIMER-1:0] TimerMax;
`endif

  sar_track_timer #(.DATA(DATA), .TIMER(TIMER), .CHANNELS(CHANNELS)) dut (
    .ClockT(ClockT), .Reset(Reset), .StateP(StateP), .SAROut(SAROut),
    .Inc(Inc), .Dcr(Dcr), .Ack(Ack), .Ready(Ready), .DataOut(DataOut),
    .TimerOut(TimerOut), .ChanOut(ChanOut), .SAROutI(SAROutI),
    .SAROutD(SAROutD), .SAROutC(SAROutC), .Overflow(Overflow), .Timeout(Timeout)
`ifdef SAR_TRACK_TIMER_HIST_EN
    , .TimerMin(TimerMin), .TimerMax(TimerMax)
`endif
  );

  // clock/reset block
  always #5 ClockT = ~ClockT;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  // reference model state
  logic [TIMER-1:0] m_cnt;
  logic m_flag_q;
  logic m_ready;
  logic [CW-1:0] m_chan;
  logic m_ovf;
  logic [RW-1:0] m_buf;
  logic [DATA-1:0] m_i, m_d, m_c;
  logic [TIMER-1:0] m_min, m_max;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_flag_q = 1'b0; m_ready = 1'b0; m_chan = '0; m_ovf = 1'b0;
    m_buf = {1'b0, {CW{1'b0}}, {TIMER{1'b0}}, DATA'(1)};
    m_i = '1; m_d = '1; m_c = '1;
    m_min = '1; m_max = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge ClockT); #1;
    Reset = 1'b1; Inc = 1'b0; Dcr = 1'b0; Ack = 1'b0; StateP = 2'b00;
    model_reset();
    #2;
    check_val("rst_ready", 32'(Ready), 32'(m_ready));
    check_val("rst_data", 32'(DataOut), 32'h1);
    check_val("rst_timer", 32'(TimerOut), 32'h0);
    check_val("rst_chan", 32'(ChanOut), 32'h0);
    check_val("rst_ovf", 32'(Overflow), 32'h0);
    check_val("rst_timeout", 32'(Timeout), 32'h0);
    check_val("rst_sar_i", 32'(SAROutI), 32'hFF);
    check_val("rst_sar_d", 32'(SAROutD), 32'hFF);
    check_val("rst_sar_c", 32'(SAROutC), 32'hFF);
`ifdef SAR_TRACK_TIMER_HIST_EN
    check_val("rst_min", 32'(TimerMin), 32'hFF);
    check_val("rst_max", 32'(TimerMax), 32'h0);
`endif
    @(negedge ClockT);
    Reset = 1'b0;
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic [1:0] sp, input logic [DATA-1:0] sar,
                      input logic inc, input logic dcr, input logic ack);
    logic fc, ev, acc;
    logic [RW-1:0] exp;
    StateP = sp; SAROut = sar; Inc = inc; Dcr = dcr; Ack = ack;
    fc = (sp == 2'b00) ? (inc | dcr) : (sp != 2'b11);
    ev = (fc && !m_flag_q) || (m_cnt == {TIMER{1'b1}});
    acc = ev && (!m_ready || ack);
    if (acc) begin
      m_buf = {(m_cnt == {TIMER{1'b1}}), m_chan, m_cnt, sar};
      exp_q.push_back(m_buf);
      if (m_cnt != {TIMER{1'b1}}) begin
        if (m_cnt < m_min) m_min = m_cnt;
        if (m_cnt > m_max) m_max = m_cnt;
      end
      m_chan = (m_chan == CW'(CHANNELS - 1)) ? '0 : m_chan + CW'(1);
      m_ready = 1'b1;
    end else begin
      if (ev) m_ovf = 1'b1;
      if (ack && m_ready) m_ready = 1'b0;
    end
    m_cnt = ev ? TIMER'(1) : m_cnt + TIMER'(1);
    m_flag_q = fc;
    if (sp == 2'b00 || sp == 2'b11) begin
      m_i = (sar == {DATA{1'b1}}) ? ~(sar - DATA'(1)) : ~sar;
      m_d = (sar == '0) ? {DATA{1'b1}} : ~(sar - DATA'(1));
    end
    m_c = ~sar;
    @(posedge ClockT); #1;
    if (acc) begin
      exp = exp_q.pop_front();
      check_val("result", 32'({Timeout, ChanOut, TimerOut, DataOut}), 32'(exp));
    end
    check_val("ready", 32'(Ready), 32'(m_ready));
    check_val("overflow", 32'(Overflow), 32'(m_ovf));
    check_val("buffer", 32'({Timeout, ChanOut, TimerOut, DataOut}), 32'(m_buf));
    check_val("sar_c", 32'(SAROutC), 32'(m_c));
    check_val("sar_i", 32'(SAROutI), 32'(m_i));
    check_val("sar_d", 32'(SAROutD), 32'(m_d));
`ifdef SAR_TRACK_TIMER_HIST_EN
    check_val("hist_min", 32'(TimerMin), 32'(m_min));
    check_val("hist_max", 32'(TimerMax), 32'(m_max));
`endif
  endtask

  initial begin
    do_reset();

    // first result after five idle cycles
    repeat (5) step(2'b00, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h5A, 1'b1, 1'b0, 1'b0);
    check_val("first_ready", 32'(Ready), 32'h1);
    check_val("first_timer", 32'(TimerOut), 32'h5);
    check_val("first_chan", 32'(ChanOut), 32'h0);
    check_val("first_data", 32'(DataOut), 32'h5A);
    step(2'b00, 8'h11, 1'b0, 1'b0, 1'b1);
    check_val("ack_clears", 32'(Ready), 32'h0);

    // overflow: second event without ack is dropped
    do_reset();
    step(2'b00, 8'h21, 1'b1, 1'b0, 1'b0);
    step(2'b00, 8'h22, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h23, 1'b0, 1'b1, 1'b0);
    check_val("ovf_set", 32'(Overflow), 32'h1);
    check_val("ovf_keep", 32'(DataOut), 32'h21);
    check_val("ovf_chan_hold", 32'(ChanOut), 32'h0);
    step(2'b00, 8'h24, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h25, 1'b1, 1'b0, 1'b1);
    check_val("ovf_next_chan", 32'(ChanOut), 32'h1);
    check_val("ovf_next_data", 32'(DataOut), 32'h25);

    // channel tag wrap over five accepted results
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 8'(i), 1'b1, 1'b0, 1'b1);
      check_val("chan_seq", 32'(ChanOut), 32'(i % CHANNELS));
      step(2'b00, 8'(i), 1'b0, 1'b0, 1'b0);
    end

    // inverted code taps
    step(2'b11, 8'hFF, 1'b0, 1'b0, 1'b1);
    check_val("tap_i_ff", 32'(SAROutI), 32'h01);
    check_val("tap_c_ff", 32'(SAROutC), 32'h00);
    step(2'b11, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("tap_i_00", 32'(SAROutI), 32'hFF);
    check_val("tap_d_00", 32'(SAROutD), 32'hFF);
    check_val("tap_c_00", 32'(SAROutC), 32'hFF);
    step(2'b11, 8'h10, 1'b0, 1'b0, 1'b1);
    check_val("tap_d_10", 32'(SAROutD), 32'hF0);
    step(2'b01, 8'h77, 1'b0, 1'b0, 1'b1);
    check_val("tap_conv_i", 32'(SAROutI), 32'hEF);
    check_val("tap_conv_d", 32'(SAROutD), 32'hF0);
    check_val("tap_conv_c", 32'(SAROutC), 32'h88);

    // counter saturation produces a timeout result, then restarts at 1
    do_reset();
    repeat (255) step(2'b11, 8'h33, 1'b0, 1'b0, 1'b0);
    check_val("pre_timeout_ready", 32'(Ready), 32'h0);
    step(2'b11, 8'h34, 1'b0, 1'b0, 1'b0);
    check_val("timeout_timer", 32'(TimerOut), 32'hFF);
    check_val("timeout_flag", 32'(Timeout), 32'h1);
    step(2'b00, 8'h35, 1'b1, 1'b0, 1'b1);
    check_val("restart_timer", 32'(TimerOut), 32'h1);
    check_val("restart_flag", 32'(Timeout), 32'h0);

`ifdef SAR_TRACK_TIMER_HIST_EN
    // history over intervals 7, 3, 9
    do_reset();
    repeat (7) step(2'b00, 8'h40, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h41, 1'b1, 1'b0, 1'b1);
    repeat (2) step(2'b00, 8'h42, 1'b0, 1'b0, 1'b1);
    step(2'b00, 8'h43, 1'b1, 1'b0, 1'b1);
    repeat (8) step(2'b00, 8'h44, 1'b0, 1'b0, 1'b1);
    step(2'b00, 8'h45, 1'b1, 1'b0, 1'b0);
    check_val("hist_min_3", 32'(TimerMin), 32'h3);
    check_val("hist_max_9", 32'(TimerMax), 32'h9);
`endif

    // random phases, requests and acknowledges
    do_reset();
    repeat (300)
      step(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));

    // reset while a result is pending; first event afterwards carries tag 0
    step(2'b00, 8'h50, 1'b0, 1'b0, 1'b1);
    step(2'b00, 8'h51, 1'b1, 1'b0, 1'b1);
    check_val("pending_ready", 32'(Ready), 32'h1);
    do_reset();
    step(2'b00, 8'h52, 1'b1, 1'b0, 1'b0);
    check_val("post_reset_ready", 32'(Ready), 32'h1);
    check_val("post_reset_chan", 32'(ChanOut), 32'h0);
    check_val("post_reset_data", 32'(DataOut), 32'h52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
